// File: rtl/pbs_loop_seq_pkg.sv
// Shared TFHE loop parameters: default geometry, derived widths and the sequencer state type.
// Widths follow the min-width-1 rule, so a dimension of 1 still gets a 1-bit index.
package pbs_loop_seq_pkg;

   localparam int GLWE_K_DEF    = 1;
   localparam int PBS_L_DEF     = 2;
   localparam int LWE_K_MAX_DEF = 8;
   localparam int BATCH_MAX_DEF = 4;

   function automatic int min_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Number of interleaved level beats per (lwe, batch) pair
   function automatic int intl_len(input int glwe_k, input int pbs_l);
      return (glwe_k + 1) * pbs_l;
   endfunction

   localparam int INTL_L      = intl_len(GLWE_K_DEF, PBS_L_DEF);
   localparam int INTL_L_W    = min_w(INTL_L);
   localparam int LWE_K_MAX_W = min_w(LWE_K_MAX_DEF);
   localparam int BATCH_MAX_W = min_w(BATCH_MAX_DEF);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } loop_state_e;

endpackage

// File: rtl/pbs_loop_seq_cnt.sv
// Wrap counter with a runtime terminal value; clear wins over enable, and the
// last flag is a pure decode of the count register.
module pbs_loop_seq_cnt #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         a_rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         last
);

   assign last = (cnt == limit);

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/pbs_loop_seq.sv
// PBS loop sequencer: walks intl (innermost), batch, then lwe indices for one
// command, emitting one index beat per out_vld/out_rdy transfer.
module pbs_loop_seq
   import pbs_loop_seq_pkg::*;
#(
   parameter int  GLWE_K      = 1,
   parameter int  PBS_L       = 2,
   parameter int  LWE_K_MAX   = 8,
   parameter int  BATCH_MAX   = 4,
   localparam int INTL_L      = intl_len(GLWE_K, PBS_L),
   localparam int INTL_L_W    = min_w(INTL_L),
   localparam int LWE_K_MAX_W = min_w(LWE_K_MAX),
   localparam int BATCH_MAX_W = min_w(BATCH_MAX),
   localparam int CFG_LWE_W   = $clog2(LWE_K_MAX + 1),
   localparam int CFG_BATCH_W = $clog2(BATCH_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   a_rst_n,
   input  logic                   start_vld,
   output logic                   start_rdy,
   input  logic [CFG_LWE_W-1:0]   cfg_lwe_k,
   input  logic [CFG_BATCH_W-1:0] cfg_batch_nb,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [LWE_K_MAX_W-1:0] out_lwe_idx,
   output logic [BATCH_MAX_W-1:0] out_batch_id,
   output logic [INTL_L_W-1:0]    out_intl_idx,
   output logic                   out_last_intl,
   output logic                   out_last_batch,
   output logic                   out_last,
   input  logic                   abort,
   output logic                   done,
   output logic                   cfg_err
);

   loop_state_e state_q;
   loop_state_e state_d;

   logic [CFG_LWE_W-1:0]   lwe_k_q;
   logic [CFG_BATCH_W-1:0] batch_nb_q;
   logic                   err_q;
   logic                   alive_q;

   logic start_acc;
   logic cfg_ok;
   logic in_run;
   logic beat_xfer;
   logic cnt_clr;

   logic intl_last;
   logic batch_last;
   logic lwe_last;

   logic [LWE_K_MAX_W-1:0] lwe_lim;
   logic [BATCH_MAX_W-1:0] batch_lim;

   // alive_q keeps start_rdy low until the first clock after reset release
   assign start_rdy = (state_q == ST_IDLE) && alive_q;
   assign start_acc = start_vld && start_rdy;
   assign in_run    = (state_q == ST_RUN);

   assign cfg_ok = (cfg_lwe_k != '0) && (cfg_lwe_k <= CFG_LWE_W'(LWE_K_MAX)) &&
                   (cfg_batch_nb != '0) && (cfg_batch_nb <= CFG_BATCH_W'(BATCH_MAX));

   // abort beats a simultaneous handshake, so it suppresses the transfer
   assign beat_xfer = in_run && out_rdy && !abort;
   assign cnt_clr   = start_acc || (in_run && abort);

   assign lwe_lim   = LWE_K_MAX_W'(lwe_k_q - CFG_LWE_W'(1));
   assign batch_lim = BATCH_MAX_W'(batch_nb_q - CFG_BATCH_W'(1));

   pbs_loop_seq_cnt #(.W(INTL_L_W)) u_intl_cnt (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .en      (beat_xfer),
      .clr     (cnt_clr),
      .limit   (INTL_L_W'(INTL_L - 1)),
      .cnt     (out_intl_idx),
      .last    (intl_last)
   );

   pbs_loop_seq_cnt #(.W(BATCH_MAX_W)) u_batch_cnt (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .en      (beat_xfer && intl_last),
      .clr     (cnt_clr),
      .limit   (batch_lim),
      .cnt     (out_batch_id),
      .last    (batch_last)
   );

   pbs_loop_seq_cnt #(.W(LWE_K_MAX_W)) u_lwe_cnt (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .en      (beat_xfer && intl_last && batch_last),
      .clr     (cnt_clr),
      .limit   (lwe_lim),
      .cnt     (out_lwe_idx),
      .last    (lwe_last)
   );

   assign out_vld        = in_run;
   assign out_last_intl  = in_run && intl_last;
   assign out_last_batch = in_run && intl_last && batch_last;
   assign out_last       = in_run && intl_last && batch_last && lwe_last;
   assign done           = (state_q == ST_DONE);
   assign cfg_err        = err_q;

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Config is captured once per command; err_q only lives through the DONE cycle
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         lwe_k_q    <= '0;
         batch_nb_q <= '0;
         err_q      <= 1'b0;
         alive_q    <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (start_acc) begin
            lwe_k_q    <= cfg_lwe_k;
            batch_nb_q <= cfg_batch_nb;
            err_q      <= !cfg_ok;
         end else if (state_q == ST_DONE) begin
            err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_acc) begin
               state_d = cfg_ok ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (beat_xfer && intl_last && batch_last && lwe_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/pbs_loop_seq.md
PBS_LOOP_SEQ -- requirements
Module: pbs_loop_seq

Interface
REQ-001 SHALL have parameter GLWE_K, default 1, meaning number of GLWE mask polynomials.
REQ-002 SHALL have parameter PBS_L, default 2, meaning PBS decomposition level count.
REQ-003 SHALL have parameter LWE_K_MAX, default 8, meaning largest runtime LWE dimension supported.
REQ-004 SHALL have parameter BATCH_MAX, default 4, meaning largest runtime batch (ciphertext channel) count.
REQ-005 SHALL have port clk, input, 1, meaning single clock.
REQ-006 SHALL have port a_rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have ports start_vld input 1 and start_rdy output 1, meaning command handshake.
REQ-008 SHALL have port cfg_lwe_k, input, clog2(LWE_K_MAX+1), meaning runtime LWE dimension, sampled with start.
REQ-009 SHALL have port cfg_batch_nb, input, clog2(BATCH_MAX+1), meaning runtime batch count, sampled with start.
REQ-010 SHALL have ports out_vld output 1 and out_rdy input 1, meaning index-beat handshake.
REQ-011 SHALL have ports out_lwe_idx (LWE_K_MAX_W), out_batch_id (BATCH_MAX_W), out_intl_idx (INTL_L_W), outputs, meaning current beat indices; all widths min 1.
REQ-012 SHALL have ports out_last_intl, out_last_batch, out_last, outputs 1, meaning end-of-level-group, end-of-batch sweep, final beat.
REQ-013 SHALL have ports abort input 1, done output 1, cfg_err output 1.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 start_rdy SHALL be 1 only in IDLE; start accepted on start_vld & start_rdy.
REQ-016 On acceptance cfg_lwe_k/cfg_batch_nb SHALL be registered; later input changes ignored.
REQ-017 If registered cfg_lwe_k is 0 or > LWE_K_MAX, or cfg_batch_nb is 0 or > BATCH_MAX: go to DONE, no beats, cfg_err=1 for one cycle with done.
REQ-018 In RUN out_vld SHALL be 1; first beat valid the cycle after acceptance.
REQ-019 Iteration order, innermost first: intl_idx 0..INTL_L-1 (INTL_L=(GLWE_K+1)*PBS_L), then batch_id 0..cfg_batch_nb-1, then lwe_idx 0..cfg_lwe_k-1.
REQ-020 Counters SHALL advance only on out_vld & out_rdy; outputs stable while out_rdy=0.
REQ-021 Wrap: intl_idx wraps to 0 and batch_id increments; batch_id wraps to 0 and lwe_idx increments.
REQ-022 out_last_intl=1 when intl_idx=INTL_L-1; out_last_batch additionally requires batch_id=cfg_batch_nb-1; out_last additionally requires lwe_idx=cfg_lwe_k-1.
REQ-023 Transfer of out_last beat SHALL move FSM to DONE; done=1 for exactly one cycle in DONE, then IDLE.
REQ-024 Total beats per command SHALL equal cfg_lwe_k*cfg_batch_nb*INTL_L.
REQ-025 abort=1 in RUN SHALL go to IDLE next cycle, out_vld=0, counters cleared, no done; abort in IDLE/DONE ignored; abort has priority over a simultaneous handshake.
REQ-026 Outputs SHALL be registered; no combinational path from out_rdy to out_vld.

Reset
REQ-027 On a_rst_n=0 asynchronously: FSM=IDLE, all counters and config registers 0, out_vld=0, done=0, cfg_err=0, start_rdy=0 until first clock after deassertion.
REQ-028 Reset mid-RUN SHALL discard the command without done.

Structure
REQ-029 INTL_L, INTL_L_W, LWE_K_MAX_W, BATCH_MAX_W and the state enum SHALL live in the shared TFHE parameter package, min-width-1 convention.
REQ-030 One sub-module natural: pbs_loop_seq_cnt, a wrap counter with runtime limit, enable, clear, last flag, instantiated three times and chained.

Verification (GLWE_K=1, PBS_L=2, LWE_K_MAX=8, BATCH_MAX=4)
REQ-031 cfg 3/2, out_rdy=1 -> 24 beats back-to-back, out_last on beat 24 (lwe 2,batch 1,intl 3), done next cycle.
REQ-032 cfg 2/1, out_rdy random 50% -> 8 beats in order, values held during stalls, count exact.
REQ-033 cfg_lwe_k=0, then cfg_lwe_k=9 -> zero beats, done and cfg_err one-cycle pulse each.
REQ-034 abort at beat 5 of cfg 8/4 -> out_vld=0 next cycle, no done, new start accepted and begins at all-zero indices.
REQ-035 a_rst_n asserted mid-RUN -> outputs 0 immediately; post-reset start cfg 1/1 gives 4 beats, flags correct.
REQ-036 cfg 8/4 -> 128 beats, out_last_intl every 4th, out_last_batch every 16th.
